// File: rtl/sm2201_pkg.sv
// sm2201_pkg: register offsets, ctrl bit positions and defaults for the SM2201 ISA bridge.
package sm2201_pkg;
    localparam logic [9:0] DEF_BASE_ADDR = 10'h100;
    localparam logic [5:0] OFS_DATA_LO   = 6'd0;
    localparam logic [5:0] OFS_DATA_HI   = 6'd1;
    localparam logic [5:0] OFS_CTRL      = 6'd2;
    localparam logic [5:0] OFS_STATUS    = 6'd3;
    localparam int         CTRL_OE       = 0;
    localparam int         CTRL_IRQ_EN   = 1;
endpackage

// File: rtl/sm2201_sync_edge.sv
// sm2201_sync_edge: 2-FF synchronizer with one-cycle rise/fall pulses on the synchronized level.
module sm2201_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_s3;

    // Two stages to resolve metastability, a third to remember the previous level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) {r_s1, r_s2, r_s3} <= '0;
        else          {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/sm2201_interface_board.sv
// sm2201_interface_board: ISA I/O window (64 bytes) bridged to the 16-bit SM2201 CAMAC data bus.
// Optional LAM interrupt path is built when SM2201_IRQ_EN is defined.
module sm2201_interface_board
    import sm2201_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 4,
    parameter int unsigned IRQ_LINE    = 3
) (
    input  logic       isa_clk,
    input  logic       isa_reset,
    input  logic       isa_ior,
    input  logic       isa_iow,
    input  logic       isa_ale,
    input  logic       isa_aen,
    input  logic [9:0] isa_addr,
    inout  wire  [7:0] isa_data,
    output logic       isa_chrdy,
    output logic [7:0] isa_irq,
    input  logic       cb_prr,
    input  logic       cb_zk4,
    inout  wire [15:0] cb_data
);
    logic [9:0]  r_addr_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_rd_snap;
    logic [15:0] r_wr_word;
    logic [1:0]  r_ctrl;
    logic        w_ior_s, w_ior_rise, w_ior_fall;
    logic        w_iow_s, w_iow_rise, w_iow_fall;
    logic        w_zk4_s, w_zk4_rise, w_zk4_fall;
    logic        w_prr_s, w_prr_rise, w_prr_fall;
    logic        w_hit, w_idle, w_rd_start, w_wr_start, w_irq_pend, w_unused;
    logic [5:0]  w_ofs;
    logic [7:0]  w_rd_mux;

    sm2201_sync_edge u_sync_ior (.i_clk(isa_clk), .i_rst_n(isa_reset), .i_d(isa_ior),
                                 .o_q(w_ior_s), .o_rise(w_ior_rise), .o_fall(w_ior_fall));
    sm2201_sync_edge u_sync_iow (.i_clk(isa_clk), .i_rst_n(isa_reset), .i_d(isa_iow),
                                 .o_q(w_iow_s), .o_rise(w_iow_rise), .o_fall(w_iow_fall));
    sm2201_sync_edge u_sync_zk4 (.i_clk(isa_clk), .i_rst_n(isa_reset), .i_d(cb_zk4),
                                 .o_q(w_zk4_s), .o_rise(w_zk4_rise), .o_fall(w_zk4_fall));
    sm2201_sync_edge u_sync_prr (.i_clk(isa_clk), .i_rst_n(isa_reset), .i_d(cb_prr),
                                 .o_q(w_prr_s), .o_rise(w_prr_rise), .o_fall(w_prr_fall));

    assign w_hit  = !isa_aen && (r_addr_q[9:6] == BASE_ADDR[9:6]);
    assign w_ofs  = r_addr_q[5:0];
    assign w_idle = (r_cnt == 4'd0);
    // A strobe edge only counts while the other strobe is high, so both-low never starts an access.
    assign w_rd_start = w_ior_fall & w_iow_s & w_hit & w_idle;
    assign w_wr_start = w_iow_fall & w_ior_s & w_hit & w_idle;

    assign w_rd_mux = (w_ofs == OFS_DATA_LO) ? r_rd_snap[7:0] :
                      (w_ofs == OFS_DATA_HI) ? r_rd_snap[15:8] :
                      (w_ofs == OFS_CTRL)    ? {6'b0, r_ctrl} :
                      (w_ofs == OFS_STATUS)  ? {5'b0, w_irq_pend, ~w_zk4_s, ~w_prr_s} : 8'h00;

    assign isa_data  = (!isa_ior && isa_iow && w_hit) ? w_rd_mux : 8'hzz;
    assign cb_data   = r_ctrl[CTRL_OE] ? r_wr_word : 16'hzzzz;
    assign isa_chrdy = w_idle;

    // Address latch, wait-state counter, CAMAC snapshot and write-side registers.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            r_addr_q  <= '0;
            r_cnt     <= '0;
            r_rd_snap <= '0;
            r_wr_word <= '0;
            r_ctrl    <= '0;
        end else begin
            if (isa_ale) r_addr_q <= isa_addr;
            if (w_rd_start || w_wr_start) r_cnt <= 4'(WAIT_STATES);
            else if (!w_idle)             r_cnt <= r_cnt - 4'd1;
            if (w_rd_start && w_ofs == OFS_DATA_LO)
                r_rd_snap <= r_ctrl[CTRL_OE] ? r_wr_word : cb_data;
            if (w_wr_start && w_ofs == OFS_DATA_LO) r_wr_word[7:0]  <= isa_data;
            if (w_wr_start && w_ofs == OFS_DATA_HI) r_wr_word[15:8] <= isa_data;
            if (w_wr_start && w_ofs == OFS_CTRL)    r_ctrl          <= isa_data[1:0];
        end
    end

`ifdef SM2201_IRQ_EN
    logic r_irq_pend;

    // LAM edge sets the pending flag; a status write clears it, but a coincident LAM wins.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset)                             r_irq_pend <= 1'b0;
        else if (w_zk4_fall)                        r_irq_pend <= 1'b1;
        else if (w_wr_start && w_ofs == OFS_STATUS) r_irq_pend <= 1'b0;
    end

    assign w_irq_pend = r_irq_pend;
    assign isa_irq    = 8'(r_irq_pend & r_ctrl[CTRL_IRQ_EN]) << IRQ_LINE;
    assign w_unused   = ^{w_ior_rise, w_iow_rise, w_zk4_rise, w_prr_rise, w_prr_fall, isa_data[7:2]};
`else
    assign w_irq_pend = 1'b0;
    assign isa_irq    = 8'h00;
    assign w_unused   = ^{w_ior_rise, w_iow_rise, w_zk4_rise, w_zk4_fall, w_prr_rise, w_prr_fall,
                          isa_data[7:2], 3'(IRQ_LINE)};
`endif
endmodule

// File: tb/tb_sm2201_interface_board.sv
// tb_sm2201_interface_board: table-driven and randomized checks of the SM2201 ISA bridge.
module tb_sm2201_interface_board;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ior, iow, ale, aen, prr, zk4, chrdy;
    logic [9:0]  addr;
    logic [7:0]  irq, td;
    logic [15:0] tc;
    logic        td_oe, tc_oe;
    tri1  [7:0]  isa_data;
    tri1  [15:0] cb_data;

    assign isa_data = td_oe ? td : 8'hzz;
    assign cb_data  = tc_oe ? tc : 16'hzzzz;

    sm2201_interface_board dut (
        .isa_clk(clk), .isa_reset(rst_n), .isa_ior(ior), .isa_iow(iow), .isa_ale(ale),
        .isa_aen(aen), .isa_addr(addr), .isa_data(isa_data), .isa_chrdy(chrdy),
        .isa_irq(irq), .cb_prr(prr), .cb_zk4(zk4), .cb_data(cb_data)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model of the register file, kept at byte/word level.
    logic [15:0] m_wr = '0, m_snap = '0;
    logic [1:0]  m_ctrl = '0;
    logic        m_pend = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_cb();
        return m_ctrl[0] ? m_wr : 16'hFFFF;
    endfunction

    function automatic logic [7:0] m_irq();
`ifdef SM2201_IRQ_EN
        return (m_pend && m_ctrl[1]) ? 8'h08 : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    task automatic set_lines(input logic p, input logic z);
`ifdef SM2201_IRQ_EN
        if (zk4 && !z) m_pend = 1'b1;
`endif
        prr = p;
        zk4 = z;
        repeat (4) @(negedge clk);
    endtask

    // kind: 0 read, 1 write, 2 both strobes low
    task automatic model(input logic [9:0] a, input int kind, input logic [7:0] wd, input logic ae,
                         input logic [15:0] cbv, output logic [7:0] er, output int ew);
        int  ofs;
        bit  hit;
        ofs = int'(a) - 'h100;
        hit = !ae && ofs >= 0 && ofs < 64 && kind != 2;
        ew  = hit ? 4 : 0;
        er  = (kind == 1) ? wd : 8'hFF;
        if (hit && kind == 0) begin
            if (ofs == 0) m_snap = m_ctrl[0] ? m_wr : cbv;
            er = ofs == 0 ? m_snap[7:0] : ofs == 1 ? m_snap[15:8] : ofs == 2 ? {6'b0, m_ctrl} :
                 ofs == 3 ? {5'b0, m_pend, ~zk4, ~prr} : 8'h00;
        end
        if (hit && kind == 1) begin
            if (ofs == 0) m_wr[7:0]  = wd;
            if (ofs == 1) m_wr[15:8] = wd;
            if (ofs == 2) m_ctrl     = wd[1:0];
            if (ofs == 3) m_pend     = 1'b0;
        end
    endtask

    task automatic access(input logic [9:0] a, input int kind, input logic [7:0] wd, input logic ae,
                          input logic [15:0] cbv, output logic [7:0] rd, output int waits);
        @(negedge clk);
        addr = a; ale = 1'b1; aen = ae;
        @(negedge clk);
        ale = 1'b0;
        tc = cbv; tc_oe = (kind == 0) && !m_ctrl[0];
        td = wd;  td_oe = (kind == 1);
        ior = (kind == 1);
        iow = (kind == 0);
        waits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!chrdy) waits++;
        end
        rd = isa_data;
        ior = 1'b1; iow = 1'b1; td_oe = 1'b0; tc_oe = 1'b0; aen = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input logic [9:0] a, input int kind, input logic [7:0] wd, input logic ae,
                       input logic [15:0] cbv, output logic [7:0] rd, output int w,
                       output logic [7:0] er, output int ew);
        access(a, kind, wd, ae, cbv, rd, w);
        model(a, kind, wd, ae, cbv, er, ew);
    endtask

    typedef struct {
        logic [9:0]  a;
        int          kind;
        logic [7:0]  wd;
        logic        ae;
        logic [7:0]  er;
        int          ew;
        logic [15:0] ecb;
    } vec_t;

    vec_t vt[18];

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rd, er, wd;
        logic [9:0]  ra;
        logic [15:0] cbv;
        logic        ae;
        int          w, ew, kind;
        logic [7:0]  st_exp;

        vt[0]  = '{10'h100, 0, 8'h00, 0, 8'h08, 4, 16'hFFFF};
        vt[1]  = '{10'h101, 0, 8'h00, 0, 8'h42, 4, 16'hFFFF};
        vt[2]  = '{10'h100, 1, 8'h34, 0, 8'h34, 4, 16'hFFFF};
        vt[3]  = '{10'h101, 1, 8'h12, 0, 8'h12, 4, 16'hFFFF};
        vt[4]  = '{10'h102, 1, 8'h01, 0, 8'h01, 4, 16'h1234};
        vt[5]  = '{10'h100, 0, 8'h00, 0, 8'h34, 4, 16'h1234};
        vt[6]  = '{10'h101, 0, 8'h00, 0, 8'h12, 4, 16'h1234};
        vt[7]  = '{10'h102, 0, 8'h00, 0, 8'h01, 4, 16'h1234};
        vt[8]  = '{10'h102, 1, 8'h00, 0, 8'h00, 4, 16'hFFFF};
        vt[9]  = '{10'h100, 0, 8'h00, 0, 8'h08, 4, 16'hFFFF};
        vt[10] = '{10'h13F, 0, 8'h00, 0, 8'h00, 4, 16'hFFFF};
        vt[11] = '{10'h13E, 1, 8'h5A, 0, 8'h5A, 4, 16'hFFFF};
        vt[12] = '{10'h0FF, 0, 8'h00, 0, 8'hFF, 0, 16'hFFFF};
        vt[13] = '{10'h140, 0, 8'h00, 0, 8'hFF, 0, 16'hFFFF};
        vt[14] = '{10'h100, 0, 8'h00, 1, 8'hFF, 0, 16'hFFFF};
        vt[15] = '{10'h0FF, 1, 8'h77, 0, 8'h77, 0, 16'hFFFF};
        vt[16] = '{10'h100, 2, 8'h00, 0, 8'hFF, 0, 16'hFFFF};
        vt[17] = '{10'h103, 0, 8'h00, 0, 8'h00, 4, 16'hFFFF};

        rst_n = 1'b0; ior = 1'b1; iow = 1'b1; ale = 1'b0; aen = 1'b0; addr = '0;
        prr = 1'b1; zk4 = 1'b1; td = '0; tc = '0; td_oe = 1'b0; tc_oe = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_chrdy", chrdy, 1);
        check("reset_irq", irq, 0);
        check("reset_isa_data", isa_data, 8'hFF);
        check("reset_cb_data", cb_data, 16'hFFFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_chrdy", chrdy, 1);

        foreach (vt[i]) begin
            run(vt[i].a, vt[i].kind, vt[i].wd, vt[i].ae, 16'h4208, rd, w, er, ew);
            check($sformatf("vec%0d_data", i), rd, vt[i].er);
            check($sformatf("vec%0d_waits", i), w, vt[i].ew);
            check($sformatf("vec%0d_cb", i), cb_data, vt[i].ecb);
            check($sformatf("vec%0d_irq", i), irq, 8'h00);
        end

        set_lines(1'b0, 1'b1);
        run(10'h103, 0, 8'h00, 0, 16'h0, rd, w, er, ew);
        check("status_prr", rd, 8'h01);
        set_lines(1'b0, 1'b0);
        run(10'h103, 0, 8'h00, 0, 16'h0, rd, w, er, ew);
`ifdef SM2201_IRQ_EN
        st_exp = 8'h07;
`else
        st_exp = 8'h03;
`endif
        check("status_zk4", rd, st_exp);
        run(10'h102, 1, 8'h02, 0, 16'h0, rd, w, er, ew);
`ifdef SM2201_IRQ_EN
        check("irq_set", irq, 8'h08);
`else
        check("irq_off", irq, 8'h00);
`endif
        run(10'h103, 1, 8'hFF, 0, 16'h0, rd, w, er, ew);
        check("irq_clear", irq, 8'h00);
        run(10'h103, 0, 8'h00, 0, 16'h0, rd, w, er, ew);
        check("status_after_clear", rd, 8'h03);

        // Strobe re-asserted while the wait counter is still running must not restart it.
        @(negedge clk);
        addr = 10'h102; ale = 1'b1;
        @(negedge clk);
        ale = 1'b0; ior = 1'b0; w = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!chrdy) w++;
            if (i == 2) ior = 1'b1;
            if (i == 3) ior = 1'b0;
        end
        ior = 1'b1;
        repeat (3) @(negedge clk);
        check("retrigger_waits", w, 4);
        set_lines(1'b1, 1'b1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) set_lines(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ra   = 10'h0F0 + 10'($urandom_range(0, 'h5F));
            kind = $urandom_range(0, 9);
            kind = kind < 5 ? 0 : kind < 9 ? 1 : 2;
            wd   = 8'($urandom);
            cbv  = 16'($urandom);
            ae   = ($urandom_range(0, 7) == 0);
            run(ra, kind, wd, ae, cbv, rd, w, er, ew);
            check($sformatf("rnd%0d_data@%0h", n, ra), rd, er);
            check($sformatf("rnd%0d_waits@%0h", n, ra), w, ew);
            check($sformatf("rnd%0d_cb", n), cb_data, m_cb());
            check($sformatf("rnd%0d_irq", n), irq, m_irq());
        end

        run(10'h100, 1, 8'hAA, 0, 16'h0, rd, w, er, ew);
        run(10'h101, 1, 8'h55, 0, 16'h0, rd, w, er, ew);
        run(10'h102, 1, 8'h01, 0, 16'h0, rd, w, er, ew);
        check("pre_reset_cb", cb_data, 16'h55AA);
        @(negedge clk);
        addr = 10'h101; ale = 1'b1;
        @(negedge clk);
        ale = 1'b0; ior = 1'b0;
        w = 0;
        while (chrdy && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("midreset_wait_started", chrdy, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_chrdy", chrdy, 1);
        check("midreset_cb", cb_data, 16'hFFFF);
        check("midreset_isa_data", isa_data, 8'hFF);
        check("midreset_irq", irq, 8'h00);
        ior = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("after_midreset_chrdy", chrdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
